flag_int_unit: RTL and testbench

FLAG_INT_UNIT -- requirements
Module: flag_int_unit

---
 rtl/flag_int_if.sv | 31 +++
 rtl/flag_int_unit.sv | 34 +++
 tb/tb_flag_int_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/flag_int_if.sv
// flag_int_if: control/status bundle between the control unit and flag_int_unit
interface flag_int_if;
  logic RST;
  logic C_IN;
  logic Z_IN;
  logic FLG_C_SET;
  logic FLG_C_CLR;
  logic FLG_C_LD;
  logic FLG_Z_LD;
  logic FLG_LD_SEL;
  logic FLG_SHAD_LD;
  logic I_SET;
  logic I_CLR;
  logic INT_ACK;
  logic INT_IN;
  logic C_FLAG;
  logic Z_FLAG;
  logic I_FLAG;
  logic INT_CU;
  logic INT_PEND;
  modport slave (
    input  RST, C_IN, Z_IN, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
           FLG_SHAD_LD, I_SET, I_CLR, INT_ACK, INT_IN,
    output C_FLAG, Z_FLAG, I_FLAG, INT_CU, INT_PEND
  );
  modport master (
    output RST, C_IN, Z_IN, FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL,
           FLG_SHAD_LD, I_SET, I_CLR, INT_ACK, INT_IN,
    input  C_FLAG, Z_FLAG, I_FLAG, INT_CU, INT_PEND
  );
endinterface

// File: rtl/flag_int_unit.sv
// flag_int_unit: carry/zero/interrupt-enable flags with shadow copies and a synchronized interrupt latch
module flag_int_unit (
  input logic       CLK,
  input logic       RESET,
  flag_int_if.slave bus
);
  logic r_c, r_z, r_i, r_shad_c, r_shad_z, r_pend, r_s1, r_s2, r_s3;
  logic w_c, w_z, w_i, w_shad_c, w_shad_z, w_pend, w_rise, w_src_c, w_src_z;
  always_comb begin
    w_src_c  = bus.FLG_LD_SEL ? r_shad_c : bus.C_IN;
    w_src_z  = bus.FLG_LD_SEL ? r_shad_z : bus.Z_IN;
    w_c      = bus.RST ? 1'b0 : bus.FLG_C_CLR ? 1'b0 : bus.FLG_C_SET ? 1'b1 : bus.FLG_C_LD ? w_src_c : r_c;
    w_z      = bus.RST ? 1'b0 : bus.FLG_Z_LD ? w_src_z : r_z;
    w_shad_c = bus.RST ? 1'b0 : bus.FLG_SHAD_LD ? r_c : r_shad_c;
    w_shad_z = bus.RST ? 1'b0 : bus.FLG_SHAD_LD ? r_z : r_shad_z;
    w_i      = bus.RST ? 1'b0 : bus.I_CLR ? 1'b0 : bus.I_SET ? 1'b1 : r_i;
    w_rise   = r_s2 & ~r_s3;
    w_pend   = bus.RST ? 1'b0 : w_rise ? 1'b1 : bus.INT_ACK ? 1'b0 : r_pend;
  end
  // synchronizer flops ignore soft reset so a held request is not re-detected
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      {r_c, r_z, r_i, r_shad_c, r_shad_z, r_pend} <= '0;
      {r_s1, r_s2, r_s3} <= '0;
    end else begin
      {r_c, r_z, r_i, r_shad_c, r_shad_z, r_pend} <= {w_c, w_z, w_i, w_shad_c, w_shad_z, w_pend};
      {r_s1, r_s2, r_s3} <= {bus.INT_IN, r_s1, r_s2};
    end
  assign bus.C_FLAG   = r_c;
  assign bus.Z_FLAG   = r_z;
  assign bus.I_FLAG   = r_i;
  assign bus.INT_PEND = r_pend;
  assign bus.INT_CU   = r_pend & r_i;
endmodule

// File: tb/tb_flag_int_unit.sv
// tb_flag_int_unit: directed scenarios plus randomized run against a history-based reference model
module tb_flag_int_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int total = 0;
  int bad = 0;
  bit m_c, m_z, m_i, m_sc, m_sz, m_p;
  bit hist[$];
  flag_int_if bus ();
  flag_int_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic clear_inputs();
    {bus.RST, bus.C_IN, bus.Z_IN, bus.FLG_C_SET, bus.FLG_C_CLR, bus.FLG_C_LD, bus.FLG_Z_LD,
     bus.FLG_LD_SEL, bus.FLG_SHAD_LD, bus.I_SET, bus.I_CLR, bus.INT_ACK} = '0;
  endtask
  task automatic model_reset();
    {m_c, m_z, m_i, m_sc, m_sz, m_p} = '0;
    hist = '{1'b0, 1'b0, 1'b0};
  endtask
  // hist[0] is INT_IN seen at the previous edge, hist[1] two edges back, hist[2] three back
  task automatic tick();
    bit nc, nz, ni, nsc, nsz, np, rise, smp;
    rise = hist[1] && !hist[2];
    smp = bus.INT_IN;
    if (bus.RST) begin
      {nc, nz, ni, nsc, nsz, np} = '0;
    end else begin
      nc = m_c;
      if (bus.FLG_C_CLR) nc = 1'b0;
      else if (bus.FLG_C_SET) nc = 1'b1;
      else if (bus.FLG_C_LD) nc = bus.FLG_LD_SEL ? m_sc : bus.C_IN;
      nz = bus.FLG_Z_LD ? (bus.FLG_LD_SEL ? m_sz : bus.Z_IN) : m_z;
      nsc = bus.FLG_SHAD_LD ? m_c : m_sc;
      nsz = bus.FLG_SHAD_LD ? m_z : m_sz;
      ni = bus.I_CLR ? 1'b0 : (bus.I_SET ? 1'b1 : m_i);
      np = rise ? 1'b1 : (bus.INT_ACK ? 1'b0 : m_p);
    end
    @(posedge CLK);
    hist.push_front(smp);
    void'(hist.pop_back());
    #1;
    {m_c, m_z, m_i, m_sc, m_sz, m_p} = {nc, nz, ni, nsc, nsz, np};
  endtask
  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic test_reset();
    clear_inputs();
    bus.INT_IN = 1'b0;
    RESET = 1'b0;
    model_reset();
    #12;
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU});
    end
    @(posedge CLK);
    #3 RESET = 1'b1;
    ticks(2);
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND} !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle got=%b want=0000", {bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND});
    end
  endtask
  task automatic test_flag_priority();
    bus.FLG_C_SET = 1'b1; bus.FLG_C_CLR = 1'b1;
    tick();
    total++;
    if (bus.C_FLAG !== 1'b0) begin bad++; $display("FAIL clr_over_set got=%b want=0", bus.C_FLAG); end
    clear_inputs();
    bus.FLG_C_SET = 1'b1; bus.FLG_C_LD = 1'b1; bus.C_IN = 1'b0;
    tick();
    total++;
    if (bus.C_FLAG !== 1'b1) begin bad++; $display("FAIL set_over_ld got=%b want=1", bus.C_FLAG); end
    clear_inputs();
    bus.FLG_C_LD = 1'b1; bus.C_IN = 1'b0; bus.FLG_Z_LD = 1'b1; bus.Z_IN = 1'b1;
    tick();
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG} !== 2'b01) begin bad++; $display("FAIL ld_from_alu got=%b want=01", {bus.C_FLAG, bus.Z_FLAG}); end
    clear_inputs();
    bus.FLG_C_SET = 1'b1; bus.RST = 1'b1;
    tick();
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG} !== 2'b00) begin bad++; $display("FAIL rst_over_set got=%b want=00", {bus.C_FLAG, bus.Z_FLAG}); end
    clear_inputs();
  endtask
  task automatic test_shadow_swap();
    bus.FLG_Z_LD = 1'b1; bus.Z_IN = 1'b1;
    tick();
    clear_inputs();
    bus.FLG_SHAD_LD = 1'b1;
    tick();
    clear_inputs();
    bus.FLG_C_SET = 1'b1; bus.FLG_Z_LD = 1'b1; bus.Z_IN = 1'b0;
    tick();
    clear_inputs();
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG} !== 2'b10) begin bad++; $display("FAIL swap_setup got=%b want=10", {bus.C_FLAG, bus.Z_FLAG}); end
    bus.FLG_SHAD_LD = 1'b1; bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1; bus.FLG_LD_SEL = 1'b1;
    tick();
    clear_inputs();
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG} !== 2'b01) begin bad++; $display("FAIL swap_flags got=%b want=01", {bus.C_FLAG, bus.Z_FLAG}); end
    bus.FLG_C_LD = 1'b1; bus.FLG_Z_LD = 1'b1; bus.FLG_LD_SEL = 1'b1;
    tick();
    clear_inputs();
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG} !== 2'b10) begin bad++; $display("FAIL swap_shadows got=%b want=10", {bus.C_FLAG, bus.Z_FLAG}); end
  endtask
  task automatic test_interrupt_latency();
    bus.I_SET = 1'b1;
    tick();
    clear_inputs();
    bus.INT_IN = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      bus.INT_ACK = (e == 4);
      tick();
      total++;
      if (bus.INT_PEND !== (e == 2 || e == 3) || bus.INT_CU !== (e == 2 || e == 3)) begin
        bad++;
        $display("FAIL latency_edge%0d pend=%b cu=%b want=%b", e, bus.INT_PEND, bus.INT_CU, (e == 2 || e == 3));
      end
    end
    clear_inputs();
    bus.INT_IN = 1'b0;
    ticks(3);
  endtask
  task automatic test_masked();
    bus.I_CLR = 1'b1; bus.I_SET = 1'b1;
    tick();
    clear_inputs();
    bus.INT_IN = 1'b1;
    ticks(6);
    total++;
    if ({bus.I_FLAG, bus.INT_PEND, bus.INT_CU} !== 3'b010) begin
      bad++;
      $display("FAIL masked_hold i/pend/cu got=%b want=010", {bus.I_FLAG, bus.INT_PEND, bus.INT_CU});
    end
    bus.I_SET = 1'b1;
    tick();
    clear_inputs();
    total++;
    if (bus.INT_CU !== 1'b1) begin bad++; $display("FAIL unmask_cu got=%b want=1", bus.INT_CU); end
    bus.INT_ACK = 1'b1;
    tick();
    clear_inputs();
    bus.INT_IN = 1'b0;
    ticks(3);
    total++;
    if (bus.INT_PEND !== 1'b0) begin bad++; $display("FAIL masked_ack got=%b want=0", bus.INT_PEND); end
  endtask
  task automatic test_ack_collision();
    bus.INT_IN = 1'b1; tick();
    bus.INT_IN = 1'b0; tick();
    bus.INT_IN = 1'b1; tick();
    tick();
    total++;
    if (bus.INT_PEND !== 1'b1) begin bad++; $display("FAIL coll_pre got=%b want=1", bus.INT_PEND); end
    bus.INT_ACK = 1'b1;
    tick();
    total++;
    if (bus.INT_PEND !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b want=1", bus.INT_PEND); end
    tick();
    total++;
    if (bus.INT_PEND !== 1'b0) begin bad++; $display("FAIL coll_ack_after got=%b want=0", bus.INT_PEND); end
    clear_inputs();
    bus.INT_IN = 1'b0;
    ticks(3);
  endtask
  task automatic test_reset_mid();
    bus.FLG_C_SET = 1'b1; bus.I_SET = 1'b1; bus.INT_IN = 1'b1;
    tick();
    clear_inputs();
    ticks(2);
    total++;
    if ({bus.C_FLAG, bus.INT_PEND} !== 2'b11) begin bad++; $display("FAIL mid_setup got=%b want=11", {bus.C_FLAG, bus.INT_PEND}); end
    #2 RESET = 1'b0;
    model_reset();
    #1;
    total++;
    if ({bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU} !== 5'b0) begin
      bad++;
      $display("FAIL mid_async got=%b want=00000", {bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU});
    end
    #1 RESET = 1'b1;
    ticks(3);
    total++;
    if (bus.INT_PEND !== 1'b1) begin bad++; $display("FAIL release_high_edge got=%b want=1", bus.INT_PEND); end
    bus.RST = 1'b1; bus.FLG_C_SET = 1'b1;
    tick();
    clear_inputs();
    total++;
    if ({bus.C_FLAG, bus.INT_PEND} !== 2'b00) begin bad++; $display("FAIL soft_rst got=%b want=00", {bus.C_FLAG, bus.INT_PEND}); end
    ticks(4);
    total++;
    if (bus.INT_PEND !== 1'b0) begin bad++; $display("FAIL soft_rst_no_edge got=%b want=0", bus.INT_PEND); end
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.RST = ($urandom_range(0, 24) == 0);
      bus.C_IN = $urandom_range(0, 1);
      bus.Z_IN = $urandom_range(0, 1);
      bus.FLG_C_SET = ($urandom_range(0, 3) == 0);
      bus.FLG_C_CLR = ($urandom_range(0, 3) == 0);
      bus.FLG_C_LD = ($urandom_range(0, 2) == 0);
      bus.FLG_Z_LD = ($urandom_range(0, 2) == 0);
      bus.FLG_LD_SEL = $urandom_range(0, 1);
      bus.FLG_SHAD_LD = ($urandom_range(0, 3) == 0);
      bus.I_SET = ($urandom_range(0, 5) == 0);
      bus.I_CLR = ($urandom_range(0, 5) == 0);
      bus.INT_ACK = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) bus.INT_IN = ~bus.INT_IN;
      tick();
      total++;
      if ({bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU} !== {m_c, m_z, m_i, m_p, m_p & m_i}) begin
        bad++;
        $display("FAIL random_%0d c/z/i/pend/cu got=%b want=%b", n,
                 {bus.C_FLAG, bus.Z_FLAG, bus.I_FLAG, bus.INT_PEND, bus.INT_CU}, {m_c, m_z, m_i, m_p, m_p & m_i});
      end
    end
    clear_inputs();
  endtask
  initial begin
    test_reset();
    test_flag_priority();
    test_shadow_swap();
    test_interrupt_latency();
    test_masked();
    test_ack_collision();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
